// File: rtl/alarme_ctrl.sv
// Alarm-system controller: timed Moore FSM for exit delay, entry delay and siren
// timeout, with a sticky cause latch and a saturating alarm-event counter.
`timescale 1ns/1ps
module alarme_ctrl #(
  parameter int EXIT_CYCLES  = 8,
  parameter int ENTRY_CYCLES = 6,
  parameter int SIREN_CYCLES = 10,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       disarm,
  input  logic       door,
  input  logic       window,
  input  logic       motion,
  output logic       siren,
  output logic       armed,
  output logic       pending,
  output logic [2:0] state,
  output logic [2:0] zone_latch,
  output logic [7:0] event_cnt
);

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);

  // Event counter sticks at its ceiling instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    if (val == 8'hFF) begin
      sat_inc = 8'hFF;
    end else begin
      sat_inc = val + 8'd1;
    end
  endfunction

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]       zone_latch_r, zone_nxt_s;
  logic [7:0]       event_cnt_r, evt_nxt_s;
  logic             siren_r, armed_r, pending_r;
  logic             alarm_go_s;
  logic [2:0]       cause_s;

  // Next-state, counter, cause latch and event counter decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    zone_nxt_s  = zone_latch_r;
    evt_nxt_s   = event_cnt_r;
    alarm_go_s  = 1'b0;
    cause_s     = 3'b000;
    if (disarm) begin
      state_nxt_s = ST_DISARMED;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_DISARMED: begin
          if (arm) begin
            state_nxt_s = ST_EXIT;
            cnt_nxt_s   = EXIT_LOAD;
            zone_nxt_s  = 3'b000;
          end else begin
            state_nxt_s = ST_DISARMED;
          end
        end
        ST_EXIT: begin
          if (cnt_r == CNT_ZERO) begin
            state_nxt_s = ST_ARMED;
          end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end
        end
        ST_ARMED: begin
          if (window || motion) begin
            alarm_go_s = 1'b1;
            cause_s    = {motion, window, door};
          end else if (door) begin
            state_nxt_s = ST_ENTRY;
            cnt_nxt_s   = ENTRY_LOAD;
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end
        ST_ENTRY: begin
          if (window || motion) begin
            alarm_go_s = 1'b1;
            cause_s    = {motion, window, door};
          end else if (cnt_r == CNT_ZERO) begin
            alarm_go_s = 1'b1;
            cause_s    = 3'b001;
          end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end
        end
        ST_ALARM: begin
          if (cnt_r == CNT_ZERO) begin
            state_nxt_s = ST_ARMED;
          end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_nxt_s = ST_DISARMED;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
    if (alarm_go_s) begin
      state_nxt_s = ST_ALARM;
      cnt_nxt_s   = SIREN_LOAD;
      zone_nxt_s  = zone_latch_r | cause_s;
      evt_nxt_s   = sat_inc(event_cnt_r);
    end else begin
      evt_nxt_s = event_cnt_r;
    end
  end

  // State, counter and status registers; outputs decode the next state so they
  // are valid in the first cycle of each state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_DISARMED;
      cnt_r        <= CNT_ZERO;
      zone_latch_r <= 3'b000;
      event_cnt_r  <= 8'd0;
      siren_r      <= 1'b0;
      armed_r      <= 1'b0;
      pending_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      zone_latch_r <= zone_nxt_s;
      event_cnt_r  <= evt_nxt_s;
      siren_r      <= (state_nxt_s == ST_ALARM);
      armed_r      <= (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_ENTRY);
      pending_r    <= (state_nxt_s == ST_EXIT) || (state_nxt_s == ST_ENTRY);
    end
  end

  assign siren      = siren_r;
  assign armed      = armed_r;
  assign pending    = pending_r;
  assign state      = state_r;
  assign zone_latch = zone_latch_r;
  assign event_cnt  = event_cnt_r;

endmodule

// File: tb/tb_alarme_ctrl.sv
// Directed self-checking bench for alarme_ctrl with hand-computed expectations.
`timescale 1ns/1ps
module tb_alarme_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, arm, disarm, door, window, motion;
  logic       siren, armed, pending;
  logic [2:0] state, zone_latch;
  logic [7:0] event_cnt;
  int         checks = 0;
  int         errors = 0;

  alarme_ctrl dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm), .door(door),
    .window(window), .motion(motion), .siren(siren), .armed(armed),
    .pending(pending), .state(state), .zone_latch(zone_latch), .event_cnt(event_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_to_armed(input string tag);
    arm = 1'b1;
    step();
    arm = 1'b0;
    check({tag, "_exit_state"}, {29'd0, state}, 32'd1);
    repeat (7) step();
    check({tag, "_exit_last"}, {29'd0, state}, 32'd1);
    step();
    check({tag, "_armed_state"}, {29'd0, state}, 32'd2);
    check({tag, "_armed_flag"}, {31'd0, armed}, 32'd1);
  endtask

  initial begin
    int exp_evt;
    rst_n = 1'b0; arm = 1'b0; disarm = 1'b0; door = 1'b0; window = 1'b0; motion = 1'b0;
    #12;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_outs", {29'd0, siren, armed, pending}, 32'd0);
    check("rst_zone", {29'd0, zone_latch}, 32'd0);
    check("rst_evt", {24'd0, event_cnt}, 32'd0);
    rst_n = 1'b1;
    #1;

    // 1: exit delay of exactly 8 cycles
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check("t1_exit_state", {29'd0, state}, 32'd1);
      check("t1_exit_outs", {29'd0, siren, armed, pending}, 32'b001);
      if (i < 8) step(); else begin end
    end
    step();
    check("t1_armed_state", {29'd0, state}, 32'd2);
    check("t1_armed_outs", {29'd0, siren, armed, pending}, 32'b010);

    // 2: door trip, 6-cycle entry delay, 10-cycle siren, re-arm
    door = 1'b1;
    step();
    door = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      check("t2_entry_state", {29'd0, state}, 32'd3);
      check("t2_entry_outs", {29'd0, siren, armed, pending}, 32'b011);
      if (i < 6) step(); else begin end
    end
    step();
    check("t2_zone", {29'd0, zone_latch}, 32'b001);
    check("t2_evt", {24'd0, event_cnt}, 32'd1);
    for (int i = 1; i <= 10; i++) begin
      check("t2_alarm_state", {29'd0, state}, 32'd4);
      check("t2_alarm_outs", {29'd0, siren, armed, pending}, 32'b100);
      if (i < 10) step(); else begin end
    end
    step();
    check("t2_rearm_state", {29'd0, state}, 32'd2);
    check("t2_rearm_siren", {31'd0, siren}, 32'd0);

    // 3: disarm during entry delay
    door = 1'b1;
    step();
    door = 1'b0;
    step();
    step();
    check("t3_entry3", {29'd0, state}, 32'd3);
    disarm = 1'b1;
    step();
    disarm = 1'b0;
    check("t3_disarmed", {29'd0, state}, 32'd0);
    check("t3_outs", {29'd0, siren, armed, pending}, 32'd0);
    check("t3_evt", {24'd0, event_cnt}, 32'd1);
    arm_to_armed("t3");
    check("t3_zone_cleared", {29'd0, zone_latch}, 32'd0);

    // 4: instant zones together, then arm+disarm collision
    window = 1'b1; motion = 1'b1;
    step();
    window = 1'b0; motion = 1'b0;
    check("t4_alarm", {29'd0, state}, 32'd4);
    check("t4_siren", {31'd0, siren}, 32'd1);
    check("t4_zone", {29'd0, zone_latch}, 32'b110);
    check("t4_evt", {24'd0, event_cnt}, 32'd2);
    arm = 1'b1; disarm = 1'b1;
    step();
    arm = 1'b0; disarm = 1'b0;
    check("t4_disarm_wins", {29'd0, state}, 32'd0);
    check("t4_siren_off", {31'd0, siren}, 32'd0);
    check("t4_zone_hold", {29'd0, zone_latch}, 32'b110);

    // 5: asynchronous reset during alarm
    arm_to_armed("t5");
    window = 1'b1;
    step();
    window = 1'b0;
    step();
    check("t5_siren_on", {31'd0, siren}, 32'd1);
    check("t5_evt_pre", {24'd0, event_cnt}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_siren", {31'd0, siren}, 32'd0);
    check("t5_async_state", {29'd0, state}, 32'd0);
    check("t5_async_evt", {24'd0, event_cnt}, 32'd0);
    check("t5_async_zone", {29'd0, zone_latch}, 32'd0);
    #10;
    rst_n = 1'b1;
    #1;

    // 6: held window loops ALARM->ARMED 300 times; counter saturates
    arm_to_armed("t6");
    window = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      exp_evt = (k > 255) ? 255 : k;
      step();
      check("t6_alarm", {29'd0, state}, 32'd4);
      check("t6_evt", {24'd0, event_cnt}, exp_evt);
      repeat (9) step();
      check("t6_siren_last", {31'd0, siren}, 32'd1);
      step();
      check("t6_rearm", {29'd0, state}, 32'd2);
    end
    window = 1'b0;
    check("t6_evt_final", {24'd0, event_cnt}, 32'd255);
    check("t6_zone", {29'd0, zone_latch}, 32'b010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarme_ctrl.md
Name: alarme_ctrl

Overview:
Sequential alarm-system controller that sits between the user panel (arm/disarm) and the zone sensors (door, window, motion).
- Manages exit delay, entry delay, siren timeout and trigger logging, producing the siren drive and status outputs.
- Replaces direct combinational sensor-to-siren decoding with a timed Moore FSM.

Parameters:
EXIT_CYCLES, 8, cycles spent in EXIT_DELAY after arming before the system is armed (>=1)
ENTRY_CYCLES, 6, cycles of grace after a door trip before the siren sounds (>=1)
SIREN_CYCLES, 10, cycles the siren stays on before automatic re-arm (>=1)
CNT_W, 8, width of the shared delay down-counter; all *_CYCLES must be <= 2^CNT_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
arm  in  1  single-cycle arm request
disarm  in  1  single-cycle disarm request
door  in  1  door zone open (delayed zone)
window  in  1  window zone open (instant zone)
motion  in  1  motion detector active (instant zone)
siren  out  1  siren drive
armed  out  1  high in ARMED and ENTRY_DELAY
pending  out  1  high in EXIT_DELAY or ENTRY_DELAY
state  out  3  current state code
zone_latch  out  3  {motion,window,door} zones that caused the last alarm
event_cnt  out  8  number of alarm entries since reset, saturating

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Values while rst_n=0: state=DISARMED, counter=0, zone_latch=0, event_cnt=0, siren=armed=pending=0.
- Outputs are Moore decodes of registered state. siren, armed and pending are valid in the same cycle the state is entered.
- State codes: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4. Codes 5-7 are illegal and go to DISARMED on the next edge.
- Priority at every edge: disarm > arm > sensors.
- disarm in any state: go to DISARMED. If disarm and arm are asserted together, disarm wins.
- DISARMED:
  - arm: go to EXIT_DELAY, counter loads EXIT_CYCLES-1, zone_latch clears.
  - Sensors are ignored.
- EXIT_DELAY:
  - Sensors and arm are ignored.
  - Counter decrements each cycle. At the edge where counter==0, go to ARMED.
  - Dwell is exactly EXIT_CYCLES cycles.
- ARMED:
  - window or motion: go to ALARM next edge.
  - door only: go to ENTRY_DELAY, counter loads ENTRY_CYCLES-1.
  - door together with window/motion: go to ALARM.
  - arm is ignored.
- ENTRY_DELAY:
  - window or motion: go to ALARM immediately.
  - Otherwise decrement. At counter==0, go to ALARM with door recorded as cause.
  - Dwell is ENTRY_CYCLES cycles. Door closing does not cancel the delay.
- ALARM entry:
  - zone_latch is loaded with the triggering zones, OR-ed into the current value.
  - event_cnt increments by 1, saturating at 255 (no wrap).
  - counter loads SIREN_CYCLES-1.
- ALARM:
  - siren=1.
  - Counter decrements. At counter==0, go to ARMED (re-arm); siren is on for exactly SIREN_CYCLES cycles.
  - Sensors are ignored while in ALARM. A still-open zone re-triggers from ARMED on the following edge.
- zone_latch holds until the next arm request. event_cnt clears only on reset.
- Reset mid-operation: siren and all outputs drop asynchronously. No pending delay survives reset.

Test Plan:
1. Reset, pulse arm at edge 0 -> state=1, pending=1 for 8 cycles; state=2, armed=1, pending=0 on the 9th cycle; siren=0 throughout.
2. From ARMED, door=1 one cycle -> state=3 for 6 cycles, then state=4, siren=1 for 10 cycles, zone_latch=3'b001, event_cnt=1, then state=2.
3. From ARMED, door=1, then disarm on the 3rd ENTRY_DELAY cycle -> state=0, siren never asserts, event_cnt unchanged.
4. From ARMED, window=1 and motion=1 together -> state=4 on the next edge, zone_latch=3'b110. Arm and disarm pulsed together in ALARM -> state=0.
5. During ALARM (siren=1), drop rst_n mid-cycle -> siren=0, state=0, event_cnt=0 immediately, without waiting for a clock edge.
6. Hold window=1 while armed for 300 alarm cycles (ALARM->ARMED->ALARM loop) -> event_cnt saturates at 255, never wraps to 0.
